stream_mux: RTL and testbench

//  M-input, N-bit valid/ready stream multiplexer; successor to the combinational mux2..mux16 family.

---
 rtl/stream_mux_pkg.sv | 21 ++
 rtl/stream_mux_arbiter.sv | 40 ++++
 rtl/stream_mux.sv | 155 +++++++++++++++
 tb/tb_stream_mux.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
// Shared types and helpers for the stream_mux packet-aware stream multiplexer.
//   state_t  : arbitration FSM states (IDLE = free to pick a channel,
//              LOCKED = a multi-beat packet owns the output)
//   next_ch  : modulo-M increment of a channel index
// Configuration macro used by the users of this package: STREAM_MUX_RR_EN
// ---------------------------------------------------------------------------
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Channel after ch, wrapping back to 0 at m.
    function automatic int next_ch(input int ch, input int m);
        return (ch + 1 >= m) ? 0 : ch + 1;
    endfunction

endpackage

// File: rtl/stream_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first requesting channel found when
// searching ptr, ptr+1, ... (mod M).
// Ports:
//   req     in  M   per-channel request (valid)
//   ptr     in  SW  channel that has first priority
//   gnt_id  out SW  chosen channel (0 when nothing requests)
//   gnt_any out 1   at least one channel requests
// Only instantiated by stream_mux when STREAM_MUX_RR_EN is defined.
// ---------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int M  = 4,
    localparam int SW = $clog2(M)
) (
    input  logic [M-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_id,
    output logic          gnt_any
);

    int ch;

    // Walk the ring once starting at ptr; the first hit wins.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        ch      = int'(ptr);
        for (int k = 0; k < M; k++) begin
            if (!gnt_any && req[ch]) begin
                gnt_id  = SW'(ch);
                gnt_any = 1'b1;
            end
            ch = next_ch(ch, M);
        end
    end

endmodule

// File: rtl/stream_mux.sv
// ---------------------------------------------------------------------------
// stream_mux
// M-input, N-bit valid/ready stream multiplexer with packet locking. Once a
// channel is granted it keeps the grant until its in_last beat transfers.
// A single registered output stage gives 1-cycle latency at full throughput.
// Ports:
//   clk        in  1      clock, rising edge
//   rst_n      in  1      asynchronous active-low reset
//   sel        in  SW     requested channel (external-select mode)
//   in_data    in  N x M  per-channel data
//   in_valid   in  M      per-channel valid
//   in_last    in  M      per-channel end-of-packet flag
//   in_ready   out M      per-channel ready
//   out_data   out N      registered data
//   out_last   out 1      registered end-of-packet flag
//   out_ch     out SW     channel id of the current output beat
//   out_valid  out 1      output valid
//   out_ready  in  1      consumer ready
// Configuration macro STREAM_MUX_RR_EN:
//   defined   -> round-robin arbitration among valid channels, sel ignored
//   undefined -> the channel is chosen by sel (sel >= M selects nothing)
// ---------------------------------------------------------------------------
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int M  = 4,
    localparam int SW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] sel,
    input  logic [N-1:0]  in_data [M],
    input  logic [M-1:0]  in_valid,
    input  logic [M-1:0]  in_last,
    output logic [M-1:0]  in_ready,
    output logic [N-1:0]  out_data,
    output logic          out_last,
    output logic [SW-1:0] out_ch,
    output logic          out_valid,
    input  logic          out_ready
);

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] grant_reg;
    logic [SW-1:0] grant;
    logic          grant_ok;
    logic          en;
    logic          xfer;
    logic [N-1:0]  beat_data;
    logic          beat_last;

    // The output stage can accept a new beat when empty or being drained.
    assign en        = ~out_valid | out_ready;
    assign xfer      = |(in_valid & in_ready);
    assign beat_data = in_data[grant];
    assign beat_last = in_last[grant];

`ifdef STREAM_MUX_RR_EN
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] arb_id;
    logic          arb_any;
    logic          unused_sel;

    assign unused_sel = ^sel;

    rr_arbiter #(.M(M)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_id  (arb_id),
        .gnt_any (arb_any)
    );

    // Priority moves past the channel whose packet just finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer && beat_last) begin
            rr_ptr <= SW'(next_ch(int'(grant), M));
        end
    end
`endif

    // While LOCKED the latched grant is authoritative and always legal;
    // in IDLE the grant is recomputed every cycle.
    always_comb begin
        grant    = grant_reg;
        grant_ok = 1'b1;
        if (state == IDLE) begin
`ifdef STREAM_MUX_RR_EN
            grant    = arb_id;
            grant_ok = arb_any;
`else
            grant    = sel;
            grant_ok = (int'(sel) < M);
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a non-last beat opens a packet, a last beat closes it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (xfer && !beat_last) state_next = LOCKED;
            LOCKED:  if (xfer &&  beat_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM output: only the granted channel sees ready, and never in reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && en && grant_ok) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Remember which channel owns the packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg <= '0;
        end else if (xfer) begin
            grant_reg <= grant;
        end
    end

    // Output register: load on input transfer, empty when drained with no
    // new beat, hold everything while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_last  <= beat_last;
            out_ch    <= grant;
        end else if (en) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// ---------------------------------------------------------------------------
// tb_stream_mux
// Self-checking bench for stream_mux (M=4 main instance, M=3 instance for the
// out-of-range select case). A behavioural model tracks what the consumer
// must see each cycle; directed checks pin the model with literal values.
// Round-robin scenarios are built when STREAM_MUX_RR_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_mux;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int SW = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [SW-1:0] sel;
    logic [N-1:0]  in_data [M];
    logic [M-1:0]  in_valid;
    logic [M-1:0]  in_last;
    logic [M-1:0]  in_ready;
    logic [N-1:0]  out_data;
    logic          out_last;
    logic [SW-1:0] out_ch;
    logic          out_valid;
    logic          out_ready;

    logic [1:0]    sel3;
    logic [N-1:0]  in_data3 [3];
    logic [2:0]    in_valid3;
    logic [2:0]    in_last3;
    logic [2:0]    in_ready3;
    logic [N-1:0]  out_data3;
    logic          out_last3;
    logic [1:0]    out_ch3;
    logic          out_valid3;
    logic          out_ready3;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [SW-1:0] ch;
        logic          last;
        logic [N-1:0]  data;
    } beat_t;

    beat_t out_q [$];

    always #5 clk = ~clk;

    stream_mux #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux #(.N(N), .M(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_last   (in_last3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_last  (out_last3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] beatWord(input int ch, input logic last,
                                             input logic [7:0] data);
        return {21'b0, ch[SW-1:0], last, data};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int ch, input logic v, input logic [7:0] d,
                                 input logic l);
        in_valid[ch] = v;
        in_data[ch]  = d;
        in_last[ch]  = l;
    endtask

    // Offer one beat on a channel and return just after it has transferred.
    task automatic sendBeat(input int ch, input logic [7:0] d, input logic l);
        int waited = 0;
        applyStimulus(ch, 1'b1, d, l);
        @(negedge clk);
        while (!in_ready[ch] && waited < 30) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready[ch]) begin
            tests++;
            fails++;
            $display("[TB] FAIL send_timeout ch%0d: in_ready 0, required 1", ch);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    // Consumer-side record of every beat that left the mux.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            out_q.push_back({out_ch, out_last, out_data});
        end
    end

    // Behavioural model: the output register as the consumer sees it, which
    // channel owns an open packet, and (round-robin) who has priority next.
    logic          m_ov      = 1'b0;
    logic [N-1:0]  m_data    = '0;
    logic          m_last    = 1'b0;
    logic [SW-1:0] m_ch      = '0;
    logic          m_locked  = 1'b0;
    int            m_lock_ch = 0;
`ifdef STREAM_MUX_RR_EN
    int            m_rr      = 0;
`endif

    initial begin : model
        logic [M-1:0] exp_ready;
        int           g;
        logic         ok;
        logic         en_m;
        logic         take;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ov      = 1'b0;
                m_data    = '0;
                m_last    = 1'b0;
                m_ch      = '0;
                m_locked  = 1'b0;
                m_lock_ch = 0;
`ifdef STREAM_MUX_RR_EN
                m_rr      = 0;
`endif
            end
            ok = 1'b0;
            g  = 0;
            if (m_locked) begin
                g  = m_lock_ch;
                ok = 1'b1;
            end else begin
`ifdef STREAM_MUX_RR_EN
                for (int k = 0; k < M; k++) begin
                    if (!ok && in_valid[(m_rr + k) % M]) begin
                        g  = (m_rr + k) % M;
                        ok = 1'b1;
                    end
                end
`else
                g  = int'(sel);
                ok = (g < M);
`endif
            end
            en_m      = !m_ov || out_ready;
            exp_ready = '0;
            if (rst_n && ok && en_m) exp_ready[g] = 1'b1;

            checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
            checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                checkOutput("out_data", 32'(out_data), 32'(m_data));
                checkOutput("out_last", 32'(out_last), 32'(m_last));
                checkOutput("out_ch", 32'(out_ch), 32'(m_ch));
            end
            take = exp_ready[g] && in_valid[g];

            @(posedge clk);
            if (rst_n) begin
                if (take) begin
                    m_ov   = 1'b1;
                    m_data = in_data[g];
                    m_last = in_last[g];
                    m_ch   = g[SW-1:0];
                    if (in_last[g]) begin
                        m_locked = 1'b0;
`ifdef STREAM_MUX_RR_EN
                        m_rr     = (g + 1) % M;
`endif
                    end else begin
                        m_locked  = 1'b1;
                        m_lock_ch = g;
                    end
                end else if (en_m) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        sel       = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < M; i++) in_data[i] = '0;
        sel3       = '0;
        in_valid3  = '0;
        in_last3   = '0;
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) in_data3[i] = '0;

        // Power-on reset: outputs cleared asynchronously, before any clock.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("por_out_valid", 32'(out_valid), 32'd0);
        checkOutput("por_out_data", 32'(out_data), 32'd0);
        checkOutput("por_out_ch", 32'(out_ch), 32'd0);
        checkOutput("por_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);

        // Reset in the middle of a packet.
        $display("[TB] reset mid-packet");
        sel = 2'd0;
        applyStimulus(0, 1'b1, 8'h55, 1'b0);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_q.delete();
        sel = 2'd1;
        sendBeat(1, 8'h66, 1'b1);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        step(2);
        checkOutput("rst_q_size", 32'(out_q.size()), 32'd1);
        if (out_q.size() >= 1)
            checkOutput("rst_q_beat", 32'(out_q[0]), beatWord(1, 1'b1, 8'h66));

        // External select with a sel change inside the packet.
        $display("[TB] external select");
        out_q.delete();
        sel = 2'd2;
        sendBeat(2, 8'hA1, 1'b0);
        checkOutput("lat_out_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_out_data", 32'(out_data), 32'hA1);
        sel = 2'd1;
        applyStimulus(1, 1'b1, 8'hB1, 1'b1);
        sendBeat(2, 8'hA2, 1'b0);
        sendBeat(2, 8'hA3, 1'b1);
        applyStimulus(2, 1'b0, 8'h00, 1'b0);
        sendBeat(1, 8'hB1, 1'b1);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        step(2);
        begin
            logic [31:0] exp_sel [4];
            exp_sel[0] = beatWord(2, 1'b0, 8'hA1);
            exp_sel[1] = beatWord(2, 1'b0, 8'hA2);
            exp_sel[2] = beatWord(2, 1'b1, 8'hA3);
            exp_sel[3] = beatWord(1, 1'b1, 8'hB1);
            checkOutput("sel_q_size", 32'(out_q.size()), 32'd4);
            for (int i = 0; i < 4 && i < out_q.size(); i++)
                checkOutput("sel_q_beat", 32'(out_q[i]), exp_sel[i]);
        end

        // Backpressure: four stalled cycles in the middle of a stream.
        $display("[TB] backpressure");
        out_q.delete();
        sel = 2'd0;
        fork
            begin
                for (int i = 0; i < 6; i++) sendBeat(0, 8'(8'hC0 + i), (i == 5));
                applyStimulus(0, 1'b0, 8'h00, 1'b0);
            end
            begin
                step(2);
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready0", 32'(in_ready[0]), 32'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        step(2);
        checkOutput("bp_q_size", 32'(out_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < out_q.size(); i++)
            checkOutput("bp_q_beat", 32'(out_q[i]), beatWord(0, (i == 5), 8'(8'hC0 + i)));

`ifndef STREAM_MUX_RR_EN
        // Out-of-range select on the three-channel instance.
        $display("[TB] illegal select");
        sel3 = 2'd3;
        for (int i = 0; i < 3; i++) in_data3[i] = 8'(8'hD0 + i);
        in_valid3 = 3'b111;
        in_last3  = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("ill_in_ready", 32'(in_ready3), 32'd0);
            checkOutput("ill_out_valid", 32'(out_valid3), 32'd0);
            @(posedge clk);
            #1;
        end
        sel3 = 2'd2;
        @(negedge clk);
        checkOutput("legal_in_ready", 32'(in_ready3), 32'b100);
        @(posedge clk);
        #1;
        in_valid3 = 3'b000;
        @(negedge clk);
        checkOutput("legal_out_valid", 32'(out_valid3), 32'd1);
        checkOutput("legal_out_ch", 32'(out_ch3), 32'd2);
        checkOutput("legal_out_data", 32'(out_data3), 32'hD2);
        @(posedge clk);
        #1;
`else
        // Round robin over four always-valid single-beat sources.
        $display("[TB] round robin");
        doReset();
        out_q.delete();
        for (int i = 0; i < M; i++) applyStimulus(i, 1'b1, 8'(8'hE0 + i), 1'b1);
        step(8);
        in_valid = '0;
        step(2);
        checkOutput("rr_q_size", 32'(out_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < out_q.size(); i++)
            checkOutput("rr_q_beat", 32'(out_q[i]), beatWord(i % 4, 1'b1, 8'(8'hE0 + (i % 4))));

        // Round-robin lock across an idle bubble inside a packet.
        $display("[TB] round robin lock");
        doReset();
        out_q.delete();
        sendBeat(1, 8'h11, 1'b0);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        fork
            begin
                sendBeat(0, 8'h30, 1'b1);
                applyStimulus(0, 1'b0, 8'h00, 1'b0);
            end
            begin
                sendBeat(2, 8'h32, 1'b1);
                applyStimulus(2, 1'b0, 8'h00, 1'b0);
            end
            begin
                step(3);
                sendBeat(1, 8'h12, 1'b1);
                applyStimulus(1, 1'b0, 8'h00, 1'b0);
            end
        join
        step(2);
        begin
            logic [31:0] exp_lock [4];
            exp_lock[0] = beatWord(1, 1'b0, 8'h11);
            exp_lock[1] = beatWord(1, 1'b1, 8'h12);
            exp_lock[2] = beatWord(2, 1'b1, 8'h32);
            exp_lock[3] = beatWord(0, 1'b1, 8'h30);
            checkOutput("lock_q_size", 32'(out_q.size()), 32'd4);
            for (int i = 0; i < 4 && i < out_q.size(); i++)
                checkOutput("lock_q_beat", 32'(out_q[i]), exp_lock[i]);
        end
`endif

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
